// File: rtl/t5_pkg.sv
// Shared t5 definitions: bridge FSM state encodings and the read-data value returned on a failed access.
package t5_pkg;

  typedef logic [1:0] t5_br_state_t;

  localparam t5_br_state_t T5_BR_IDLE = 2'd0;
  localparam t5_br_state_t T5_BR_BUSY = 2'd1;
  localparam t5_br_state_t T5_BR_RESP = 2'd2;

  localparam logic [31:0] T5_BUSERR_DAT = 32'h0;

endpackage

// File: rtl/t5_wbtmo.sv
// Saturating Wishbone timeout counter: expire flags the last permitted BUSY cycle, combinationally.
// Cleared when a new cycle is launched; counts only while run is high; TMO=0 never expires.
module t5_wbtmo #(
  parameter int TMO = 255,
  parameter int TMW = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expire
);

  localparam logic [TMW-1:0] CNT_LAST = (TMO == 0) ? '0 : TMW'(TMO - 1);
  localparam logic [TMW-1:0] CNT_MAX  = '1;

  logic [TMW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run && (cnt != CNT_MAX)) begin
      cnt <= cnt + TMW'(1);
    end
  end

  always_comb begin
    expire = (TMO != 0) && (cnt == CNT_LAST) && run;
  end

endmodule

// File: rtl/t5_dwb_bridge.sv
// Core data port to Wishbone bridge: one registered Wishbone cycle per request, one-cycle dwb_ack back.
// Min 2 cycles per access, 3 back-to-back; bus error or timeout still completes the access and flags bus_err.
module t5_dwb_bridge
  import t5_pkg::*;
#(
  parameter int TMO = 255,
  parameter int TMW = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [29:0] dwb_adr,
  input  logic [31:0] dwb_dto,
  input  logic [3:0]  dwb_sel,
  input  logic        dwb_wre,
  input  logic        dwb_stb,
  output logic [31:0] dwb_dti,
  output logic        dwb_ack,
  output logic [29:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        err_clr,
  output logic        bus_err,
  output logic [29:0] err_adr
);

  t5_br_state_t state_q;
  t5_br_state_t state_d;

  logic tmo_expire;
  logic req_accept;
  logic busy_fail;
  logic busy_done;

  t5_wbtmo #(
    .TMO (TMO),
    .TMW (TMW)
  ) u_wbtmo (
    .clk    (sys_clk),
    .rst_n  (sys_rst),
    .clr    (req_accept),
    .run    (state_q == T5_BR_BUSY),
    .expire (tmo_expire)
  );

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q <= T5_BR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      T5_BR_IDLE: if (dwb_stb) state_d = T5_BR_BUSY;
      T5_BR_BUSY: if (wb_err_i || wb_ack_i || tmo_expire) state_d = T5_BR_RESP;
      T5_BR_RESP: state_d = T5_BR_IDLE;
      default:    state_d = T5_BR_IDLE;
    endcase
  end

  // cyc/stb decode straight from the state register, so reset drops them without waiting for a clock.
  always_comb begin
    wb_cyc_o   = (state_q == T5_BR_BUSY);
    wb_stb_o   = (state_q == T5_BR_BUSY);
    dwb_ack    = (state_q == T5_BR_RESP);
    req_accept = (state_q == T5_BR_IDLE) && dwb_stb;
    busy_fail  = (state_q == T5_BR_BUSY) && (wb_err_i || tmo_expire);
    busy_done  = (state_q == T5_BR_BUSY) && wb_ack_i;
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      wb_we_o  <= 1'b0;
    end else if (req_accept) begin
      wb_adr_o <= dwb_adr;
      wb_dat_o <= dwb_dto;
      wb_sel_o <= dwb_sel;
      wb_we_o  <= dwb_wre;
    end
  end

  // A failing termination outranks a simultaneous ack, and a new failure outranks err_clr.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      dwb_dti <= '0;
      bus_err <= 1'b0;
      err_adr <= '0;
    end else begin
      if (busy_fail) begin
        dwb_dti <= T5_BUSERR_DAT;
        err_adr <= wb_adr_o;
      end else if (busy_done) begin
        dwb_dti <= wb_dat_i;
      end

      if (busy_fail) begin
        bus_err <= 1'b1;
      end else if (err_clr) begin
        bus_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_t5_dwb_bridge.sv
// Directed bench for t5_dwb_bridge: table of single accesses plus sequences for clear, timeout, reset and back-to-back.
// A second pair of bridges (TMO=4 and TMO=0) shares one silent slave for the timeout cases.
module tb_t5_dwb_bridge;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;

  always #5 sys_clk = ~sys_clk;

  // Main bridge, default timeout.
  logic [29:0] dwb_adr = '0;
  logic [31:0] dwb_dto = '0;
  logic [3:0]  dwb_sel = '0;
  logic        dwb_wre = 1'b0;
  logic        dwb_stb = 1'b0;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        err_clr  = 1'b0;
  logic [31:0] dwb_dti;
  logic        dwb_ack;
  logic [29:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        bus_err;
  logic [29:0] err_adr;

  // Shared stimulus for the timeout bridges.
  logic [29:0] t_adr = '0;
  logic        t_stb = 1'b0;
  logic [31:0] t_dat = '0;
  logic        t_ack = 1'b0;
  logic [31:0] b_dti, c_dti, b_dat_o, c_dat_o;
  logic        b_ack, c_ack, b_we, c_we, b_cyc, c_cyc, b_stb_o, c_stb_o, b_err, c_err;
  logic [29:0] b_adr_o, c_adr_o, b_eadr, c_eadr;
  logic [3:0]  b_sel_o, c_sel_o;

  t5_dwb_bridge u_dut (
    .sys_clk (sys_clk), .sys_rst (sys_rst),
    .dwb_adr (dwb_adr), .dwb_dto (dwb_dto), .dwb_sel (dwb_sel), .dwb_wre (dwb_wre),
    .dwb_stb (dwb_stb), .dwb_dti (dwb_dti), .dwb_ack (dwb_ack),
    .wb_adr_o (wb_adr_o), .wb_dat_o (wb_dat_o), .wb_sel_o (wb_sel_o), .wb_we_o (wb_we_o),
    .wb_cyc_o (wb_cyc_o), .wb_stb_o (wb_stb_o),
    .wb_dat_i (wb_dat_i), .wb_ack_i (wb_ack_i), .wb_err_i (wb_err_i),
    .err_clr (err_clr), .bus_err (bus_err), .err_adr (err_adr)
  );

  t5_dwb_bridge #(.TMO(4)) u_tmo4 (
    .sys_clk (sys_clk), .sys_rst (sys_rst),
    .dwb_adr (t_adr), .dwb_dto (32'h0), .dwb_sel (4'hF), .dwb_wre (1'b0),
    .dwb_stb (t_stb), .dwb_dti (b_dti), .dwb_ack (b_ack),
    .wb_adr_o (b_adr_o), .wb_dat_o (b_dat_o), .wb_sel_o (b_sel_o), .wb_we_o (b_we),
    .wb_cyc_o (b_cyc), .wb_stb_o (b_stb_o),
    .wb_dat_i (t_dat), .wb_ack_i (t_ack), .wb_err_i (1'b0),
    .err_clr (1'b0), .bus_err (b_err), .err_adr (b_eadr)
  );

  t5_dwb_bridge #(.TMO(0)) u_tmo0 (
    .sys_clk (sys_clk), .sys_rst (sys_rst),
    .dwb_adr (t_adr), .dwb_dto (32'h0), .dwb_sel (4'hF), .dwb_wre (1'b0),
    .dwb_stb (t_stb), .dwb_dti (c_dti), .dwb_ack (c_ack),
    .wb_adr_o (c_adr_o), .wb_dat_o (c_dat_o), .wb_sel_o (c_sel_o), .wb_we_o (c_we),
    .wb_cyc_o (c_cyc), .wb_stb_o (c_stb_o),
    .wb_dat_i (t_dat), .wb_ack_i (t_ack), .wb_err_i (1'b0),
    .err_clr (1'b0), .bus_err (c_err), .err_adr (c_eadr)
  );

  typedef struct {
    logic [29:0] adr;
    logic [31:0] dto;
    logic [3:0]  sel;
    logic        wre;
    int          waits;
    logic [31:0] rdat;
    logic        ack;
    logic        err;
    logic [31:0] exp_dti;
    logic        exp_err;
    logic [29:0] exp_eadr;
  } vec_t;

  vec_t vecs[4];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Runs one access on the main bridge; the slave terminates after v.waits wait states.
  task automatic do_access(input int idx, input vec_t v);
    @(negedge sys_clk);
    dwb_adr = v.adr; dwb_dto = v.dto; dwb_sel = v.sel; dwb_wre = v.wre; dwb_stb = 1'b1;
    for (int i = 0; i <= v.waits; i++) begin
      @(negedge sys_clk);
      check($sformatf("v%0d_cyc%0d", idx, i), 32'(wb_cyc_o), 32'd1);
      check($sformatf("v%0d_stb%0d", idx, i), 32'(wb_stb_o), 32'd1);
      check($sformatf("v%0d_adr%0d", idx, i), 32'(wb_adr_o), 32'(v.adr));
      check($sformatf("v%0d_dat%0d", idx, i), wb_dat_o, v.dto);
      check($sformatf("v%0d_sel%0d", idx, i), 32'(wb_sel_o), 32'(v.sel));
      check($sformatf("v%0d_we%0d", idx, i), 32'(wb_we_o), 32'(v.wre));
      check($sformatf("v%0d_noack%0d", idx, i), 32'(dwb_ack), 32'd0);
      if (i == 0) begin
        dwb_adr = ~v.adr; dwb_dto = ~v.dto; dwb_sel = ~v.sel; dwb_wre = ~v.wre;
      end
      if (i == v.waits) begin
        wb_ack_i = v.ack; wb_err_i = v.err; wb_dat_i = v.rdat;
      end
    end
    @(negedge sys_clk);
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    check($sformatf("v%0d_ack", idx), 32'(dwb_ack), 32'd1);
    check($sformatf("v%0d_dti", idx), dwb_dti, v.exp_dti);
    check($sformatf("v%0d_buserr", idx), 32'(bus_err), 32'(v.exp_err));
    check($sformatf("v%0d_erradr", idx), 32'(err_adr), 32'(v.exp_eadr));
    check($sformatf("v%0d_cycoff", idx), 32'(wb_cyc_o), 32'd0);
    dwb_stb = 1'b0;
    @(negedge sys_clk);
    check($sformatf("v%0d_ackpulse", idx), 32'(dwb_ack), 32'd0);
    check($sformatf("v%0d_dtihold", idx), dwb_dti, v.exp_dti);
  endtask

  initial begin
    logic exp_ack6 [6];
    vecs[0] = '{30'h100, 32'h0, 4'hF, 1'b0, 0, 32'hCAFEF00D, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0, 30'h0};
    vecs[1] = '{30'h4, 32'h12345678, 4'b0011, 1'b1, 5, 32'h0BADBEEF, 1'b1, 1'b0, 32'h0BADBEEF, 1'b0, 30'h0};
    vecs[2] = '{30'h3F0, 32'h1, 4'hF, 1'b0, 0, 32'hDEADBEEF, 1'b1, 1'b1, 32'h0, 1'b1, 30'h3F0};
    vecs[3] = '{30'h2A, 32'h0, 4'hF, 1'b0, 2, 32'h13579BDF, 1'b1, 1'b0, 32'h13579BDF, 1'b0, 30'h0};
    exp_ack6 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    #3;
    check("rst_cyc", 32'(wb_cyc_o), 32'd0);
    check("rst_stb", 32'(wb_stb_o), 32'd0);
    check("rst_ack", 32'(dwb_ack), 32'd0);
    check("rst_dti", dwb_dti, 32'd0);
    check("rst_adr", 32'(wb_adr_o), 32'd0);
    check("rst_buserr", 32'(bus_err), 32'd0);
    check("rst_erradr", 32'(err_adr), 32'd0);
    check("rst_tmo_cyc", 32'({b_cyc, c_cyc}), 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b1;

    for (int k = 0; k < 3; k++) do_access(k, vecs[k]);

    // err_clr clears the flag but leaves the faulting address.
    @(negedge sys_clk);
    err_clr = 1'b1;
    @(negedge sys_clk);
    err_clr = 1'b0;
    check("clr_buserr", 32'(bus_err), 32'd0);
    check("clr_erradr", 32'(err_adr), 32'(30'h3F0));

    // Terminations outside BUSY are ignored.
    wb_ack_i = 1'b1; wb_err_i = 1'b1;
    @(negedge sys_clk);
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    check("idle_ack", 32'(dwb_ack), 32'd0);
    check("idle_cyc", 32'(wb_cyc_o), 32'd0);
    check("idle_buserr", 32'(bus_err), 32'd0);

    // Silent slave: TMO=4 gives up after 4 BUSY cycles, TMO=0 waits.
    t_adr = 30'h55; t_dat = 32'hFFFFFFFF; t_stb = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge sys_clk);
      check($sformatf("tmo4_cyc%0d", i), 32'(b_cyc), 32'd1);
      check($sformatf("tmo4_noack%0d", i), 32'(b_ack), 32'd0);
    end
    @(negedge sys_clk);
    t_stb = 1'b0;
    check("tmo4_cycoff", 32'(b_cyc), 32'd0);
    check("tmo4_ack", 32'(b_ack), 32'd1);
    check("tmo4_dti", b_dti, 32'd0);
    check("tmo4_buserr", 32'(b_err), 32'd1);
    check("tmo4_erradr", 32'(b_eadr), 32'(30'h55));
    @(negedge sys_clk);
    check("tmo4_ackpulse", 32'(b_ack), 32'd0);
    repeat (15) @(negedge sys_clk);
    check("tmo0_cyc", 32'(c_cyc), 32'd1);
    check("tmo0_noack", 32'(c_ack), 32'd0);
    check("tmo0_buserr", 32'(c_err), 32'd0);
    t_ack = 1'b1; t_dat = 32'h600DF00D;
    @(negedge sys_clk);
    t_ack = 1'b0;
    check("tmo0_ack", 32'(c_ack), 32'd1);
    check("tmo0_dti", c_dti, 32'h600DF00D);
    check("tmo4_idle_ack", 32'(b_ack), 32'd0);

    // Reset in the middle of a BUSY cycle.
    @(negedge sys_clk);
    dwb_adr = 30'h77; dwb_wre = 1'b0; dwb_stb = 1'b1;
    @(negedge sys_clk);
    check("midrst_busy", 32'(wb_cyc_o), 32'd1);
    dwb_stb = 1'b0;
    #2 sys_rst = 1'b0;
    #1;
    check("midrst_cyc", 32'(wb_cyc_o), 32'd0);
    check("midrst_stb", 32'(wb_stb_o), 32'd0);
    check("midrst_ack", 32'(dwb_ack), 32'd0);
    check("midrst_adr", 32'(wb_adr_o), 32'd0);
    check("midrst_erradr", 32'(err_adr), 32'd0);
    wb_ack_i = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b1; wb_ack_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge sys_clk);
      check($sformatf("postrst_ack%0d", i), 32'(dwb_ack), 32'd0);
      check($sformatf("postrst_cyc%0d", i), 32'(wb_cyc_o), 32'd0);
    end
    do_access(3, vecs[3]);

    // Back-to-back with stb held; second access errors while err_clr is high.
    @(negedge sys_clk);
    dwb_adr = 30'h10; dwb_wre = 1'b0; dwb_sel = 4'hF; dwb_stb = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge sys_clk);
      check($sformatf("b2b_ack%0d", n), 32'(dwb_ack), 32'(exp_ack6[n-1]));
      case (n)
        1: begin
          check("b2b_adr1", 32'(wb_adr_o), 32'(30'h10));
          dwb_adr = 30'h20; wb_ack_i = 1'b1; wb_dat_i = 32'h0000000A;
        end
        2: begin
          wb_ack_i = 1'b0;
          check("b2b_dti1", dwb_dti, 32'h0000000A);
          check("b2b_adrhold", 32'(wb_adr_o), 32'(30'h10));
        end
        3: check("b2b_gap", 32'(wb_cyc_o), 32'd0);
        4: begin
          check("b2b_adr2", 32'(wb_adr_o), 32'(30'h20));
          wb_err_i = 1'b1; err_clr = 1'b1;
        end
        5: begin
          wb_err_i = 1'b0; err_clr = 1'b0; dwb_stb = 1'b0;
          check("b2b_buserr", 32'(bus_err), 32'd1);
          check("b2b_erradr", 32'(err_adr), 32'(30'h20));
          check("b2b_dti2", dwb_dti, 32'd0);
        end
        default: check("b2b_idle", 32'(wb_cyc_o), 32'd0);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end of test, expected completion");
    $fatal(1);
  end

endmodule
